fetch_unit: RTL and testbench

Instruction fetch stage of the soft MIPS processor. Owns the program counter, drives the word address into the instruction memory, and presents the returned instruction with its PC and a valid flag to decode. Handles pipeline stalls with a one-entry hold register and redirects from decode (taken branch, jump) with a one-cycle squash of the wrong-path fetch.

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the soft MIPS core.
// Owns the PC, buffers one instruction across stalls, squashes on redirect.
module fetch_unit #(
   parameter int ADDR_WIDTH = 7,
   parameter int RESET_PC   = 0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   input  logic [31:0] inst_in,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic        jump_valid,
   input  logic [25:0] jump_index,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        inst_valid
);

   localparam int AW = ADDR_WIDTH;
   localparam logic [AW-1:0] PC0 = AW'(RESET_PC);

   logic [AW-1:0] pc_q;
   logic [AW-1:0] inst_pc_q;
   logic          valid_q;
   logic          hold_valid;
   logic [31:0]   hold_inst;

   logic [31:0]   off_sx;
   logic [AW-1:0] br_target;
   logic [AW-1:0] target;
   logic          redirect;
   logic          unused;

   assign off_sx    = {{16{branch_offset[15]}}, branch_offset};
   assign br_target = inst_pc_q + AW'(1) + off_sx[AW-1:0];
   assign unused    = ^{off_sx[31:AW], jump_index[25:AW]};

   // Redirects only act on a correct-path instruction that decode consumes.
   assign redirect = !stall && valid_q && (jump_valid || branch_taken);

   always_comb begin
      target = br_target;
      if (jump_valid) begin
         target = jump_index[AW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= PC0;
         inst_pc_q  <= '0;
         valid_q    <= 1'b0;
         hold_valid <= 1'b0;
         hold_inst  <= '0;
      end else if (stall) begin
         // Memory keeps re-reading pc_q, so latch the presented word once.
         if (!hold_valid) begin
            hold_inst  <= inst_in;
            hold_valid <= 1'b1;
         end
      end else if (redirect) begin
         pc_q       <= target;
         inst_pc_q  <= pc_q;
         valid_q    <= 1'b0;
         hold_valid <= 1'b0;
      end else begin
         pc_q       <= pc_q + AW'(1);
         inst_pc_q  <= pc_q;
         valid_q    <= 1'b1;
         hold_valid <= 1'b0;
      end
   end

   assign pc         = {{(32-AW){1'b0}}, pc_q};
   assign inst_pc    = {{(32-AW){1'b0}}, inst_pc_q};
   assign inst_valid = valid_q;
   assign inst_out   = hold_valid ? hold_inst : inst_in;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random stimulus against a program-flow model.
// Model: accepted stream starts at RESET_PC, follows redirects, else +1.
module tb_fetch_unit;

   localparam int AW  = 7;
   localparam int RPC = 0;
   localparam int NW  = 1 << AW;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_offset = '0;
   logic        jump_valid = 1'b0;
   logic [25:0] jump_index = '0;
   logic [31:0] pc;
   logic [31:0] inst_in;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_valid;

   logic [31:0] mem [NW];

   int n_chk  = 0;
   int n_fail = 0;

   int          expq[$];
   bit          exp_valid  = 0;
   bit          started    = 0;
   bit          post_reset = 0;
   bit          held       = 0;
   logic [31:0] prev_out;
   logic [31:0] prev_pc;
   int          ma;
   int          mt;

   fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .inst_in      (inst_in),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_offset(branch_offset),
      .jump_valid   (jump_valid),
      .jump_index   (jump_index),
      .inst_out     (inst_out),
      .inst_pc      (inst_pc),
      .inst_valid   (inst_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) inst_in <= mem[pc[AW-1:0]];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % NW) + NW) % NW;
   endfunction

   // Monitor: checks presented outputs, then advances the flow model
   // using the inputs that the coming edge will sample.
   always @(negedge clk) begin
      if (started) begin
         chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
         chk("pc_upper", pc >> AW, 0);
         if (post_reset) begin
            chk("reset_pc", pc, RPC);
            chk("reset_inst_pc", inst_pc, 0);
            chk("reset_inst_out", inst_out, inst_in);
         end
         if (held) begin
            chk("stall_inst_out", inst_out, prev_out);
            chk("stall_inst_pc", inst_pc, prev_pc);
         end
         if (exp_valid) begin
            chk("inst_pc", inst_pc, 32'(expq[0]));
            chk("inst_out", inst_out, mem[expq[0]]);
         end
      end
      prev_out = inst_out;
      prev_pc  = inst_pc;
      if (reset) begin
         expq.delete();
         expq.push_back(RPC);
         exp_valid  = 0;
         post_reset = 1;
         held       = 0;
         started    = 1;
      end else if (!started) begin
         held = 0;
      end else if (stall) begin
         held       = 1;
         post_reset = 0;
      end else begin
         held       = 0;
         post_reset = 0;
         if (exp_valid) begin
            ma = expq.pop_front();
            if (jump_valid) begin
               mt = int'(jump_index) % NW;
               exp_valid = 0;
            end else if (branch_taken) begin
               mt = wrap(ma + 1 + int'($signed(branch_offset)));
               exp_valid = 0;
            end else begin
               mt = wrap(ma + 1);
            end
            expq.push_back(mt);
         end else begin
            exp_valid = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall         = 1'b0;
      branch_taken  = 1'b0;
      jump_valid    = 1'b0;
      branch_offset = '0;
      jump_index    = '0;
   endtask

   // addr < 0 waits for any valid instruction
   task automatic wait_for(input int addr);
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (inst_valid && (addr < 0 || inst_pc == 32'(addr))) ok = 1;
         else step();
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_for: got inst_pc %0d expected %0d", inst_pc, addr);
      end
   endtask

   initial begin
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      mem[0] = 32'h018B6020;
      mem[1] = 32'h118BFFFE;
      mem[2] = 32'h018B6020;

      reset = 1'b1;
      idle();
      repeat (3) step();
      reset = 1'b0;

      wait_for(1);
      branch_taken  = 1'b1;
      branch_offset = 16'hFFFE;
      step();
      idle();
      chk("branch_bubble", 32'(inst_valid), 0);
      step();
      chk("branch_target_pc", inst_pc, 0);
      chk("branch_target_inst", inst_out, 32'h018B6020);

      wait_for(2);
      stall = 1'b1;
      repeat (3) step();
      stall = 1'b0;
      chk("stall_release_pc", inst_pc, 2);
      step();
      chk("after_stall_pc", inst_pc, 3);

      wait_for(-1);
      jump_valid    = 1'b1;
      jump_index    = 26'h40;
      branch_taken  = 1'b1;
      branch_offset = 16'd5;
      step();
      idle();
      chk("jump_bubble", 32'(inst_valid), 0);
      step();
      chk("jump_priority_pc", inst_pc, 32'h40);

      wait_for(-1);
      stall      = 1'b1;
      jump_valid = 1'b1;
      jump_index = 26'h10;
      step();
      idle();
      step();
      chk("stall_drops_jump", 32'(inst_valid), 1);

      wait_for(-1);
      jump_valid = 1'b1;
      jump_index = 26'd126;
      step();
      idle();
      wait_for(126);
      step();
      chk("wrap_127", inst_pc, 127);
      step();
      chk("wrap_0", inst_pc, 0);
      branch_taken  = 1'b1;
      branch_offset = 16'hFFFD;
      step();
      idle();
      step();
      chk("neg_branch_wrap", inst_pc, 126);

      wait_for(-1);
      stall = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      stall = 1'b0;
      chk("reset_mid_stall_pc", pc, RPC);
      chk("reset_mid_stall_valid", 32'(inst_valid), 0);

      repeat (3000) begin
         stall         = ($urandom % 4) == 0;
         branch_taken  = ($urandom % 5) == 0;
         branch_offset = ($urandom % 2) ? 16'($urandom)
                                        : 16'(int'($urandom_range(16)) - 8);
         jump_valid    = ($urandom % 9) == 0;
         jump_index    = 26'($urandom);
         reset         = ($urandom % 300) == 0;
         step();
      end
      reset = 1'b0;
      idle();
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
